// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: sequential fetch addresses, pipelined IM req/gnt + rvalid, in-order prefetch queue.
// Optional FETCH_ALIGN_CHECK_EN adds Instr_AdEL and traps misaligned redirect targets.

module fetch_prefetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_PC   = 32'h0000_4180,
   parameter int          DEPTH    = 4,
   parameter int          MAX_OUT  = 2
) (
   input  logic        Clk,
   input  logic        Rst,
   output logic        Imem_Req,
   output logic [31:0] Imem_Addr,
   input  logic        Imem_Gnt,
   input  logic        Imem_RValid,
   input  logic [31:0] Imem_RData,
   input  logic        Instr_Take,
   output logic        Instr_Valid,
   output logic [31:0] Instr,
   output logic [31:0] PC,
   output logic [31:0] PC8_Out,
   input  logic        Redirect,
   input  logic [31:0] Redirect_PC,
   input  logic        ActivateCP0,
   input  logic        CoolCP0,
   input  logic [31:0] EPC
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic        Instr_AdEL
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   logic [31:0]   fpc;
   logic [CW-1:0] count;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [OW-1:0] outstanding, outstanding_nxt, drop_cnt;
   logic [AW-1:0] af_rd, af_wr;
   logic [31:0]   af_mem  [MAX_OUT];
   logic [31:0]   q_pc    [DEPTH];
   logic [31:0]   q_instr [DEPTH];
   logic [31:0]   target;
   logic          redirect_ev, slot_free, grant, push, pop, halted, bad_target;

   // NOTE: every path through this block assigns every output, so no latch is inferred.
   always_comb begin
      redirect_ev = ActivateCP0 | CoolCP0 | Redirect;
      if (ActivateCP0)
         target = EXC_PC;
      else if (CoolCP0)
         target = EPC;
      else
         target = Redirect_PC;
   end

   // A request is only issued if the queue is guaranteed a slot for its response.
   assign slot_free       = (32'(count) + 32'(outstanding)) < DEPTH;
   assign Imem_Req        = !Rst && !redirect_ev && !halted && (32'(outstanding) < MAX_OUT) && slot_free;
   assign Imem_Addr       = fpc;
   assign grant           = Imem_Req & Imem_Gnt;
   assign push            = Imem_RValid && (drop_cnt == '0) && !redirect_ev;
   assign pop             = Instr_Take && (count != '0) && !redirect_ev;
   assign outstanding_nxt = outstanding + OW'(grant) - OW'(Imem_RValid);

`ifdef FETCH_ALIGN_CHECK_EN
   logic q_adel [DEPTH];

   assign bad_target = redirect_ev && (target[1:0] != 2'b00);
   assign Instr_AdEL = Instr_Valid & q_adel[rd_ptr];

   // Fetching stays halted after a misaligned target until the next redirect event.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         halted <= 1'b0;
      else if (redirect_ev)
         halted <= bad_target;
   end

   always_ff @(posedge Clk) begin
      if (bad_target)
         q_adel[0] <= 1'b1;
      else if (push)
         q_adel[wr_ptr] <= 1'b0;
   end
`else
   assign bad_target = 1'b0;
   assign halted     = 1'b0;
`endif

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         fpc         <= RESET_PC;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
         af_rd       <= '0;
         af_wr       <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         if (grant)
            af_wr <= (32'(af_wr) == MAX_OUT - 1) ? '0 : af_wr + AW'(1);
         if (Imem_RValid)
            af_rd <= (32'(af_rd) == MAX_OUT - 1) ? '0 : af_rd + AW'(1);
         if (redirect_ev) begin
            // Every response still in flight after this edge belongs to the old stream.
            fpc      <= target & ~32'h3;
            drop_cnt <= outstanding_nxt;
            rd_ptr   <= '0;
            wr_ptr   <= PW'(bad_target);
            count    <= CW'(bad_target);
         end else begin
            if (grant)
               fpc <= fpc + 32'd4;
            if (Imem_RValid && (drop_cnt != '0))
               drop_cnt <= drop_cnt - OW'(1);
            if (push)
               wr_ptr <= wr_ptr + PW'(1);
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // NOTE: storage arrays carry no reset; count and pointers alone define which entries are live.
   always_ff @(posedge Clk) begin
      if (grant)
         af_mem[af_wr] <= fpc;
      if (bad_target) begin
         q_pc[0]    <= target;
         q_instr[0] <= '0;
      end else if (push) begin
         q_pc[wr_ptr]    <= af_mem[af_rd];
         q_instr[wr_ptr] <= Imem_RData;
      end
   end

   assign Instr_Valid = (count != '0);
   assign Instr       = q_instr[rd_ptr];
   assign PC          = q_pc[rd_ptr];
   assign PC8_Out     = PC + 32'd8;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: IM responder with variable latency and
// random grants, reference model tracking the expected in-order PC stream.

module tb_fetch_prefetch_queue;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC   = 32'h0000_4180;
   localparam int          DEPTH    = 4;
   localparam int          MAX_OUT  = 2;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Imem_Req;
   logic [31:0] Imem_Addr;
   logic        Imem_Gnt;
   logic        Imem_RValid;
   logic [31:0] Imem_RData;
   logic        Instr_Take;
   logic        Instr_Valid;
   logic [31:0] Instr;
   logic [31:0] PC;
   logic [31:0] PC8_Out;
   logic        Redirect;
   logic [31:0] Redirect_PC;
   logic        ActivateCP0;
   logic        CoolCP0;
   logic [31:0] EPC;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        Instr_AdEL;
   bit          halted_m;
   bit          adel_pending;
`endif

   always #5 Clk = ~Clk;

   fetch_prefetch_queue #(
      .RESET_PC(RESET_PC), .EXC_PC(EXC_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)
   ) dut (
      .Clk(Clk), .Rst(Rst),
      .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr), .Imem_Gnt(Imem_Gnt),
      .Imem_RValid(Imem_RValid), .Imem_RData(Imem_RData),
      .Instr_Take(Instr_Take), .Instr_Valid(Instr_Valid), .Instr(Instr),
      .PC(PC), .PC8_Out(PC8_Out),
      .Redirect(Redirect), .Redirect_PC(Redirect_PC),
      .ActivateCP0(ActivateCP0), .CoolCP0(CoolCP0),
`ifdef FETCH_ALIGN_CHECK_EN
      .EPC(EPC), .Instr_AdEL(Instr_AdEL)
`else
      .EPC(EPC)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } im_req_t;

   im_req_t     pending[$];
   int          take_cyc[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          n_taken = 0;
   int          lat = 1;
   int          gnt_pct = 100;
   logic [31:0] exp_pc = RESET_PC;
   logic [31:0] fetch_next = RESET_PC;

   function automatic logic [31:0] imem_word(logic [31:0] a);
      return a * 32'h9E37_79B1 + 32'h1357_9BDF;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample and check at the falling edge, then act as IM after the rising edge.
   task automatic step();
      logic        ev;
      logic        req_s;
      logic [31:0] addr_s;
      logic [31:0] tgt;
      im_req_t     r;
      @(negedge Clk);
      ev     = ActivateCP0 | CoolCP0 | Redirect;
      tgt    = ActivateCP0 ? EXC_PC : (CoolCP0 ? EPC : Redirect_PC);
      req_s  = Imem_Req;
      addr_s = Imem_Addr;
      if (ev)
         check("event_no_req", {31'b0, req_s}, 32'd0);
      if (req_s && Imem_Gnt) begin
         check("fetch_addr", addr_s, fetch_next);
         fetch_next = fetch_next + 32'd4;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      if (halted_m)
         check("halt_no_req", {31'b0, req_s}, 32'd0);
      if (halted_m && !adel_pending)
         check("halt_empty", {31'b0, Instr_Valid}, 32'd0);
`endif
      if (!ev && Instr_Take && Instr_Valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
         if (adel_pending) begin
            check("adel_pc", PC, exp_pc);
            check("adel_instr", Instr, 32'd0);
            check("adel_flag", {31'b0, Instr_AdEL}, 32'd1);
            adel_pending = 1'b0;
         end else begin
            check("head_pc", PC, exp_pc);
            check("head_instr", Instr, imem_word(exp_pc));
            check("head_pc8", PC8_Out, exp_pc + 32'd8);
            check("head_adel", {31'b0, Instr_AdEL}, 32'd0);
            exp_pc = exp_pc + 32'd4;
         end
`else
         check("head_pc", PC, exp_pc);
         check("head_instr", Instr, imem_word(exp_pc));
         check("head_pc8", PC8_Out, exp_pc + 32'd8);
         exp_pc = exp_pc + 32'd4;
`endif
         n_taken++;
         take_cyc.push_back(cyc);
      end
      if (ev) begin
`ifdef FETCH_ALIGN_CHECK_EN
         halted_m     = (tgt[1:0] != 2'b00);
         adel_pending = halted_m;
         exp_pc       = halted_m ? tgt : tgt;
         fetch_next   = tgt;
`else
         exp_pc     = tgt & ~32'h3;
         fetch_next = exp_pc;
`endif
      end
      @(posedge Clk);
      #1;
      cyc++;
      if (req_s && Imem_Gnt) begin
         r.addr = addr_s;
         r.due  = cyc + lat - 1;
         pending.push_back(r);
      end
      if (pending.size() > 0 && pending[0].due <= cyc) begin
         Imem_RValid = 1'b1;
         Imem_RData  = imem_word(pending[0].addr);
         void'(pending.pop_front());
      end else begin
         Imem_RValid = 1'b0;
         Imem_RData  = $urandom;
      end
      Imem_Gnt    = ($urandom_range(99) < gnt_pct);
      Redirect    = 1'b0;
      ActivateCP0 = 1'b0;
      CoolCP0     = 1'b0;
   endtask

   task automatic run_until_take(int budget, string tag);
      int start;
      start = n_taken;
      for (int i = 0; i < budget && n_taken == start; i++)
         step();
      check(tag, {31'b0, n_taken > start}, 32'd1);
   endtask

   initial begin
      int k;
      int base;
      Rst = 1'b1;
      Imem_Gnt = 1'b1;
      Imem_RValid = 1'b0;
      Imem_RData = '0;
      Instr_Take = 1'b0;
      Redirect = 1'b0;
      Redirect_PC = '0;
      ActivateCP0 = 1'b0;
      CoolCP0 = 1'b0;
      EPC = '0;
`ifdef FETCH_ALIGN_CHECK_EN
      halted_m = 1'b0;
      adel_pending = 1'b0;
`endif
      repeat (2) @(posedge Clk);
      #1;
      check("rst_req", {31'b0, Imem_Req}, 32'd0);
      check("rst_valid", {31'b0, Instr_Valid}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
      check("rst_adel", {31'b0, Instr_AdEL}, 32'd0);
`endif
      Rst = 1'b0;
      #1;
      check("rel_addr", Imem_Addr, RESET_PC);
      check("rel_req", {31'b0, Imem_Req}, 32'd1);
      check("rel_valid", {31'b0, Instr_Valid}, 32'd0);

      // 1: 1-cycle IM, ID always taking -> one instruction per cycle
      Instr_Take = 1'b1;
      for (int i = 0; i < 20 && n_taken < 3; i++)
         step();
      check("t1_three_takes", 32'(n_taken), 32'd3);
      if (take_cyc.size() >= 3) begin
         check("t1_consec_a", 32'(take_cyc[1] - take_cyc[0]), 32'd1);
         check("t1_consec_b", 32'(take_cyc[2] - take_cyc[1]), 32'd1);
      end

      // 2: ID stalled -> queue fills to DEPTH and fetching stops
      Instr_Take = 1'b0;
      repeat (12) step();
      check("t2_no_pending", 32'(pending.size()), 32'd0);
      check("t2_req_low", {31'b0, Imem_Req}, 32'd0);
      check("t2_valid", {31'b0, Instr_Valid}, 32'd1);
      check("t2_occupancy", (fetch_next - exp_pc) >> 2, 32'(DEPTH));
      Instr_Take = 1'b1;
      base = n_taken;
      repeat (8) step();
      check("t2_resume", {31'b0, (n_taken - base) >= 4}, 32'd1);

      // 3: redirect with two requests in flight, then back-to-back redirects
      lat = 3;
      for (int i = 0; i < 30 && pending.size() != 2; i++)
         step();
      check("t3_two_inflight", 32'(pending.size()), 32'd2);
      Redirect = 1'b1;
      Redirect_PC = 32'h0000_3100;
      step();
      run_until_take(20, "t3_take_after_redirect");
      repeat (3) step();
      Redirect = 1'b1;
      Redirect_PC = 32'h0000_3200;
      step();
      Redirect = 1'b1;
      Redirect_PC = 32'h0000_3300;
      step();
      run_until_take(20, "t3_take_after_b2b");

      // 4: exception beats redirect; ERET beats redirect
      lat = 1;
      repeat (4) step();
      ActivateCP0 = 1'b1;
      Redirect = 1'b1;
      Redirect_PC = 32'h0000_5000;
      step();
      check("t4_exc_empty", {31'b0, Instr_Valid}, 32'd0);
      run_until_take(10, "t4_take_exc");
      repeat (4) step();
      CoolCP0 = 1'b1;
      EPC = 32'h0000_3010;
      Redirect = 1'b1;
      Redirect_PC = 32'h0000_6000;
      step();
      check("t4_eret_empty", {31'b0, Instr_Valid}, 32'd0);
      run_until_take(10, "t4_take_eret");

      // 5: 3-cycle IM, random grant stalls, random take and occasional redirect events
      lat = 3;
      gnt_pct = 60;
      base = n_taken;
      for (int i = 0; i < 600; i++) begin
         Instr_Take = ($urandom_range(99) < 70);
         if ($urandom_range(99) < 4) begin
            k = $urandom_range(3);
            Redirect = 1'b1;
            Redirect_PC = 32'h0000_3000 + ($urandom_range(1023) << 2);
            if (k == 1)
               ActivateCP0 = 1'b1;
            if (k == 2) begin
               CoolCP0 = 1'b1;
               EPC = 32'h0000_3000 + ($urandom_range(1023) << 2);
            end
         end
         step();
      end
      check("t5_progress", {31'b0, (n_taken - base) > 50}, 32'd1);

      // 6: misaligned redirect target
      lat = 1;
      gnt_pct = 100;
      Instr_Take = 1'b1;
      repeat (4) step();
      Redirect = 1'b1;
      Redirect_PC = 32'h0000_3102;
      step();
      run_until_take(10, "t6_take_misaligned");
      repeat (5) step();
      Redirect = 1'b1;
      Redirect_PC = 32'h0000_3000;
      step();
      run_until_take(10, "t6_take_after_recover");

      // 7: reset asserted mid-stream
      repeat (3) step();
      #2;
      Rst = 1'b1;
      #1;
      check("t7_rst_req", {31'b0, Imem_Req}, 32'd0);
      check("t7_rst_valid", {31'b0, Instr_Valid}, 32'd0);
      pending.delete();
      Imem_RValid = 1'b0;
      exp_pc = RESET_PC;
      fetch_next = RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
      halted_m = 1'b0;
      adel_pending = 1'b0;
`endif
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      run_until_take(10, "t7_take_after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
